// File: rtl/load_align_pkg.sv
// Shared definitions for the load alignment block: load-type codes, FSM states, size decode.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package load_align_pkg;

    // WidthSrc load-type encoding; bit 2 set means zero-extend
    localparam logic [2:0] WS_LB   = 3'b000;
    localparam logic [2:0] WS_LH   = 3'b001;
    localparam logic [2:0] WS_LW   = 3'b010;
    localparam logic [2:0] WS_LD   = 3'b011;
    localparam logic [2:0] WS_LBU  = 3'b100;
    localparam logic [2:0] WS_LHU  = 3'b101;
    localparam logic [2:0] WS_LWU  = 3'b110;
    localparam logic [2:0] WS_RSVD = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BEAT0 = 2'd1,
        ST_BEAT1 = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Access size in bytes; the reserved code decodes to 8 but is always rejected as illegal
    function automatic logic [3:0] ws_size(input logic [2:0] ws);
        case (ws)
            WS_LB, WS_LBU:  return 4'd1;
            WS_LH, WS_LHU:  return 4'd2;
            WS_LW, WS_LWU:  return 4'd4;
            default:        return 4'd8;
        endcase
    endfunction

    // Reserved code is never legal; doubleword and unsigned-word loads need a 64-bit datapath
    function automatic logic ws_illegal(input logic [2:0] ws, input int xlen);
        return (ws == WS_RSVD) || ((xlen == 32) && ((ws == WS_LD) || (ws == WS_LWU)));
    endfunction

endpackage

// File: rtl/load_extend.sv
// Combinational byte-align and sign/zero-extend of a two-word load window.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; output follows inputs.
module load_extend
    import load_align_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2*XLEN-1:0]         pair_i,
    input  logic [$clog2(XLEN/8)-1:0] offset_i,
    input  logic [2:0]                width_src_i,
    output logic [XLEN-1:0]           ext_o
);

    localparam int NB = XLEN / 8;

    logic [XLEN-1:0] low;
    logic            msb;
    logic            fill;
    int              sz;

    // Shift the byte window down, keep size bytes, fill the rest with the sign or zeros
    always_comb begin
        low   = XLEN'(pair_i >> {offset_i, 3'b000});
        sz    = int'(ws_size(width_src_i));
        msb   = 1'b0;
        ext_o = '0;
        case (ws_size(width_src_i))
            4'd1:    msb = low[7];
            4'd2:    msb = low[15];
            4'd4:    msb = low[31];
            default: msb = low[XLEN-1];
        endcase
        fill = ~width_src_i[2] & msb;
        for (int i = 0; i < NB; i++) begin
            ext_o[i*8 +: 8] = (i < sz) ? low[i*8 +: 8] : {8{fill}};
        end
    end

endmodule

// File: rtl/load_align.sv
// Load aligner: accepts a load request, collects one or two memory beats, returns aligned/extended data.
// Latency: result registered 1 cycle after the final beat handshake (1 cycle after request on error).
// Backpressure: valid/ready on all three channels; result held in DONE until res_ready, no bypass to IDLE.
module load_align
    import load_align_pkg::*;
#(
    parameter int XLEN          = 32,
    parameter int MISALIGNED_EN = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [2:0]                WidthSrc,
    input  logic [$clog2(XLEN/8)-1:0] Offset,
    input  logic                      rdata_valid,
    output logic                      rdata_ready,
    input  logic [XLEN-1:0]           rdata,
    output logic                      res_valid,
    input  logic                      res_ready,
    output logic [XLEN-1:0]           Result,
    output logic                      res_err
);

    localparam int NB   = XLEN / 8;
    localparam int OFFW = $clog2(XLEN / 8);

    state_t            state_q;
    logic [2:0]        ws_q;
    logic [OFFW-1:0]   off_q;
    logic              span_q;
    logic [XLEN-1:0]   beat0_q;
    logic [XLEN-1:0]   result_q;
    logic              err_q;
    logic              req_ready_q;
    logic              rdata_ready_q;
    logic              res_valid_q;

    logic              req_span_d;
    logic              req_illegal_d;
    logic [2*XLEN-1:0] pair_d;
    logic [XLEN-1:0]   ext_d;

    // Classify the incoming request and build the two-word window for the extender
    always_comb begin
        req_illegal_d = ws_illegal(WidthSrc, XLEN);
        req_span_d    = (int'(Offset) + int'(ws_size(WidthSrc))) > NB;
        pair_d        = (state_q == ST_BEAT1) ? {rdata, beat0_q} : {{XLEN{1'b0}}, rdata};
    end

    load_extend #(
        .XLEN(XLEN)
    ) u_extend (
        .pair_i      (pair_d),
        .offset_i    (off_q),
        .width_src_i (ws_q),
        .ext_o       (ext_d)
    );

    // Control FSM with registered handshake outputs and result
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            ws_q          <= '0;
            off_q         <= '0;
            span_q        <= 1'b0;
            beat0_q       <= '0;
            result_q      <= '0;
            err_q         <= 1'b0;
            req_ready_q   <= 1'b1;
            rdata_ready_q <= 1'b0;
            res_valid_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        ws_q        <= WidthSrc;
                        off_q       <= Offset;
                        span_q      <= req_span_d;
                        req_ready_q <= 1'b0;
                        if (req_illegal_d || (req_span_d && (MISALIGNED_EN == 0))) begin
                            result_q    <= '0;
                            err_q       <= 1'b1;
                            res_valid_q <= 1'b1;
                            state_q     <= ST_DONE;
                        end else begin
                            rdata_ready_q <= 1'b1;
                            state_q       <= ST_BEAT0;
                        end
                    end
                end
                ST_BEAT0: begin
                    if (rdata_valid) begin
                        beat0_q <= rdata;
                        if (span_q) begin
                            state_q <= ST_BEAT1;
                        end else begin
                            result_q      <= ext_d;
                            err_q         <= 1'b0;
                            rdata_ready_q <= 1'b0;
                            res_valid_q   <= 1'b1;
                            state_q       <= ST_DONE;
                        end
                    end
                end
                ST_BEAT1: begin
                    if (rdata_valid) begin
                        result_q      <= ext_d;
                        err_q         <= 1'b0;
                        rdata_ready_q <= 1'b0;
                        res_valid_q   <= 1'b1;
                        state_q       <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (res_ready) begin
                        res_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready   = req_ready_q;
    assign rdata_ready = rdata_ready_q;
    assign res_valid   = res_valid_q;
    assign Result      = result_q;
    assign res_err     = err_q;

endmodule

// File: tb/tb_load_align.sv
module tb_load_align;
    import load_align_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    always #5 clk = ~clk;

    // Main DUT (misaligned loads serviced)
    logic        req_valid, req_ready;
    logic [2:0]  WidthSrc;
    logic [1:0]  Offset;
    logic        rdata_valid, rdata_ready;
    logic [31:0] rdata;
    logic        res_valid, res_ready;
    logic [31:0] Result;
    logic        res_err;

    // Second DUT (misaligned loads flagged)
    logic        nm_req_valid, nm_req_ready;
    logic [2:0]  nm_WidthSrc;
    logic [1:0]  nm_Offset;
    logic        nm_rdata_valid, nm_rdata_ready;
    logic [31:0] nm_rdata;
    logic        nm_res_valid, nm_res_ready;
    logic [31:0] nm_Result;
    logic        nm_res_err;

    load_align #(.XLEN(32), .MISALIGNED_EN(1)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .WidthSrc(WidthSrc), .Offset(Offset),
        .rdata_valid(rdata_valid), .rdata_ready(rdata_ready), .rdata(rdata),
        .res_valid(res_valid), .res_ready(res_ready),
        .Result(Result), .res_err(res_err)
    );

    load_align #(.XLEN(32), .MISALIGNED_EN(0)) dut_nm (
        .clk(clk), .reset(reset),
        .req_valid(nm_req_valid), .req_ready(nm_req_ready),
        .WidthSrc(nm_WidthSrc), .Offset(nm_Offset),
        .rdata_valid(nm_rdata_valid), .rdata_ready(nm_rdata_ready), .rdata(nm_rdata),
        .res_valid(nm_res_valid), .res_ready(nm_res_ready),
        .Result(nm_Result), .res_err(nm_res_err)
    );

    typedef struct packed {
        logic        err;
        logic [31:0] res;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   n_beats  = 0;
    int   n_rdy    = 0;
    int   nm_rdy   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Data-beat handshakes counted at the edge where they happen
    always @(posedge clk) begin
        if (rdata_valid && rdata_ready) n_beats++;
    end

    // Scoreboard: compare every consumed result against the queued expectation
    always @(negedge clk) begin : mon
        exp_t e;
        if (rdata_ready) n_rdy++;
        if (nm_rdata_ready) nm_rdy++;
        if (res_valid && res_ready) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_result", 64'd1, 64'd0);
            end else begin
                e = exp_q.pop_front();
                check("sb_result", 64'(Result), 64'(e.res));
                check("sb_err", 64'(res_err), 64'(e.err));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] ws, input logic [1:0] off);
        int t;
        req_valid = 1'b1;
        WidthSrc  = ws;
        Offset    = off;
        t = 0;
        while (!req_ready && t < 20) begin
            tick();
            t++;
        end
        if (t >= 20) check("req_ready_timeout", 64'd1, 64'd0);
        tick();
        req_valid = 1'b0;
    endtask

    task automatic beat(input logic [31:0] d);
        int t;
        rdata_valid = 1'b1;
        rdata       = d;
        t = 0;
        while (!rdata_ready && t < 20) begin
            tick();
            t++;
        end
        if (t >= 20) check("rdata_ready_timeout", 64'd1, 64'd0);
        tick();
        rdata_valid = 1'b0;
        rdata       = 32'hDEAD_BEEF;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (res_valid && t < 20) begin
            tick();
            t++;
        end
        if (t >= 20) check("drain_timeout", 64'd1, 64'd0);
    endtask

    task automatic run_load(input logic [2:0] ws, input logic [1:0] off, input logic [31:0] b0,
                            input logic [31:0] b1, input bit two, input logic [31:0] exp_res,
                            input string tag);
        int nb0;
        nb0 = n_beats;
        exp_q.push_back({1'b0, exp_res});
        issue(ws, off);
        beat(b0);
        if (two) begin
            check({tag, "_mid_valid"}, 64'(res_valid), 64'd0);
            beat(b1);
        end
        check({tag, "_latency"}, 64'(res_valid), 64'd1);
        check({tag, "_beats"}, 64'(n_beats - nb0), two ? 64'd2 : 64'd1);
        drain();
    endtask

    task automatic run_err(input logic [2:0] ws, input logic [1:0] off, input string tag);
        int r0;
        r0 = n_rdy;
        exp_q.push_back({1'b1, 32'h0});
        issue(ws, off);
        check({tag, "_valid"}, 64'(res_valid), 64'd1);
        check({tag, "_err"}, 64'(res_err), 64'd1);
        check({tag, "_result"}, 64'(Result), 64'd0);
        drain();
        check({tag, "_no_rdata_ready"}, 64'(n_rdy - r0), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        req_valid = 1'b0; WidthSrc = 3'b0; Offset = 2'b0;
        rdata_valid = 1'b0; rdata = 32'h0; res_ready = 1'b1;
        nm_req_valid = 1'b0; nm_WidthSrc = 3'b0; nm_Offset = 2'b0;
        nm_rdata_valid = 1'b0; nm_rdata = 32'h0; nm_res_ready = 1'b1;

        repeat (2) tick();
        check("rst_req_ready", 64'(req_ready), 64'd1);
        check("rst_rdata_ready", 64'(rdata_ready), 64'd0);
        check("rst_res_valid", 64'(res_valid), 64'd0);
        check("rst_result", 64'(Result), 64'd0);
        check("rst_res_err", 64'(res_err), 64'd0);
        reset = 1'b1;
        tick();

        // Aligned and sub-word loads
        run_load(WS_LB,  2'd3, 32'h8012_3456, 32'h0, 1'b0, 32'hFFFF_FF80, "lb_off3");
        run_load(WS_LHU, 2'd2, 32'hBEEF_0000, 32'h0, 1'b0, 32'h0000_BEEF, "lhu_off2");
        run_load(WS_LBU, 2'd1, 32'h0000_F000, 32'h0, 1'b0, 32'h0000_00F0, "lbu_off1");
        run_load(WS_LW,  2'd0, 32'h1234_5678, 32'h0, 1'b0, 32'h1234_5678, "lw_off0");

        // Spanning loads
        run_load(WS_LW, 2'd2, 32'hAABB_CCDD, 32'h1122_3344, 1'b1, 32'h3344_AABB, "lw_span");
        run_load(WS_LH, 2'd3, 32'hAB00_0000, 32'h0000_00CD, 1'b1, 32'hFFFF_CDAB, "lh_span");

        // Illegal requests on a 32-bit datapath
        run_err(WS_LD,   2'd0, "err_ld");
        run_err(WS_LWU,  2'd0, "err_lwu");
        run_err(WS_RSVD, 2'd1, "err_rsvd");

        // Misaligned word on the instance that flags spans
        nm_req_valid = 1'b1; nm_WidthSrc = WS_LW; nm_Offset = 2'd2;
        tick();
        nm_req_valid = 1'b0;
        check("nm_valid", 64'(nm_res_valid), 64'd1);
        check("nm_err", 64'(nm_res_err), 64'd1);
        check("nm_result", 64'(nm_Result), 64'd0);
        tick();
        check("nm_back_idle", 64'(nm_req_ready), 64'd1);
        check("nm_no_rdata_ready", 64'(nm_rdy), 64'd0);

        // Result held while the consumer stalls
        res_ready = 1'b0;
        exp_q.push_back({1'b0, 32'hFFFF_ABCD});
        issue(WS_LH, 2'd1);
        beat(32'h00AB_CD00);
        for (int i = 0; i < 3; i++) begin
            check("stall_result", 64'(Result), 64'hFFFF_ABCD);
            check("stall_valid", 64'(res_valid), 64'd1);
            check("stall_req_ready", 64'(req_ready), 64'd0);
            tick();
        end
        res_ready = 1'b1;
        tick();
        check("stall_idle_req_ready", 64'(req_ready), 64'd1);
        check("stall_idle_res_valid", 64'(res_valid), 64'd0);

        // Reset while waiting for the second beat
        issue(WS_LW, 2'd2);
        beat(32'hAABB_CCDD);
        check("pre_rst_rdata_ready", 64'(rdata_ready), 64'd1);
        reset = 1'b0;
        tick();
        check("mid_rst_req_ready", 64'(req_ready), 64'd1);
        check("mid_rst_rdata_ready", 64'(rdata_ready), 64'd0);
        check("mid_rst_res_valid", 64'(res_valid), 64'd0);
        check("mid_rst_result", 64'(Result), 64'd0);
        check("mid_rst_res_err", 64'(res_err), 64'd0);
        reset = 1'b1;
        tick();
        run_load(WS_LB, 2'd0, 32'h0000_007F, 32'h0, 1'b0, 32'h0000_007F, "post_rst_lb");

        repeat (3) tick();
        check("sb_empty", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
